reorder_buffer: RTL and testbench

Circular reorder buffer between the decoder/issue stage and the RegFile. It allocates an entry per issued instruction and supplies that entry's ROB id to the RegFile for rename. It captures results from the common data bus and retires entries in program order, one per cycle, as register writes into the RegFile. On a mispredicted branch reaching the head, it raises the global roll-back flag and flushes.

---
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 tb/tb_reorder_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates an id per issued instruction, captures CDB
// results, retires in program order into the RegFile and flushes on a mispredict.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ID_issue_valid,
  input  logic                ID_rd_valid,
  input  logic [4:0]          ID_rd,
  input  logic                ID_is_branch,
  output logic                ROB_full,
  output logic [ROB_ID_W-1:0] ROB_tail_id,
  input  logic                CDB_valid,
  input  logic [ROB_ID_W-1:0] CDB_ROB_id,
  input  logic [31:0]         CDB_value,
  input  logic                CDB_mispredict,
  input  logic [31:0]         CDB_target_pc,
  input  logic [ROB_ID_W-1:0] Q1_ROB_id,
  input  logic [ROB_ID_W-1:0] Q2_ROB_id,
  output logic                Q1_ready,
  output logic                Q2_ready,
  output logic [31:0]         Q1_value,
  output logic [31:0]         Q2_value,
  output logic                RF_commit_valid,
  output logic [4:0]          RF_commit_rd,
  output logic [31:0]         RF_commit_value,
  output logic                ROB_roll_back_flag,
  output logic [31:0]         ROB_target_pc
);

  localparam logic [ROB_ID_W:0] FULL_COUNT = (ROB_ID_W+1)'(ROB_SIZE);

  logic [ROB_ID_W-1:0] head_reg;
  logic [ROB_ID_W-1:0] tail_reg;
  logic [ROB_ID_W:0]   count_reg;

  logic [ROB_SIZE-1:0] busy_vec;
  logic [ROB_SIZE-1:0] ready_vec;
  logic [ROB_SIZE-1:0] rd_valid_vec;
  logic [ROB_SIZE-1:0] is_branch_vec;
  logic [ROB_SIZE-1:0] mispredict_vec;
  logic [4:0]          rd_arr        [ROB_SIZE];
  logic [31:0]         value_arr     [ROB_SIZE];
  logic [31:0]         target_pc_arr [ROB_SIZE];

  logic issue_fire;
  logic wb_fire;
  logic commit_fire;
  logic flush;

  assign ROB_full    = (count_reg == FULL_COUNT);
  assign ROB_tail_id = tail_reg;

  assign commit_fire = rdy && busy_vec[head_reg] && ready_vec[head_reg];
  assign flush       = commit_fire && is_branch_vec[head_reg] && mispredict_vec[head_reg];
  // A full buffer still accepts an issue when the head retires in the same cycle.
  assign issue_fire  = rdy && ID_issue_valid && (!ROB_full || commit_fire)
                       && !ROB_roll_back_flag && !flush;
  assign wb_fire     = rdy && CDB_valid && !ROB_roll_back_flag && busy_vec[CDB_ROB_id];

  genvar gi;
  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
      localparam logic [ROB_ID_W-1:0] IDX = ROB_ID_W'(gi);

      logic        issue_here;
      logic        wb_here;
      logic        commit_here;
      logic        busy_reg;
      logic        ready_reg;
      logic        rd_valid_reg;
      logic        is_branch_reg;
      logic        mispredict_reg;
      logic [4:0]  rd_reg;
      logic [31:0] value_reg;
      logic [31:0] target_pc_reg;

      assign issue_here  = issue_fire && (tail_reg == IDX);
      assign wb_here     = wb_fire && (CDB_ROB_id == IDX);
      assign commit_here = commit_fire && (head_reg == IDX);

      // Reissue into the slot being retired wins over the retire's clear.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_reg <= 1'b0;
        end else if (flush) begin
          busy_reg <= 1'b0;
        end else if (issue_here) begin
          busy_reg <= 1'b1;
        end else if (commit_here) begin
          busy_reg <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (issue_here) begin
          ready_reg     <= 1'b0;
          rd_valid_reg  <= ID_rd_valid;
          rd_reg        <= ID_rd;
          is_branch_reg <= ID_is_branch;
        end else if (wb_here) begin
          ready_reg      <= 1'b1;
          value_reg      <= CDB_value;
          mispredict_reg <= CDB_mispredict;
          target_pc_reg  <= CDB_target_pc;
        end
      end

      assign busy_vec[gi]       = busy_reg;
      assign ready_vec[gi]      = ready_reg;
      assign rd_valid_vec[gi]   = rd_valid_reg;
      assign is_branch_vec[gi]  = is_branch_reg;
      assign mispredict_vec[gi] = mispredict_reg;
      assign rd_arr[gi]         = rd_reg;
      assign value_arr[gi]      = value_reg;
      assign target_pc_arr[gi]  = target_pc_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg           <= '0;
      tail_reg           <= '0;
      count_reg          <= '0;
      RF_commit_valid    <= 1'b0;
      RF_commit_rd       <= '0;
      RF_commit_value    <= '0;
      ROB_roll_back_flag <= 1'b0;
      ROB_target_pc      <= '0;
    end else begin
      RF_commit_valid    <= commit_fire && rd_valid_vec[head_reg];
      ROB_roll_back_flag <= flush;
      if (commit_fire) begin
        RF_commit_rd    <= rd_arr[head_reg];
        RF_commit_value <= value_arr[head_reg];
      end
      if (flush) begin
        ROB_target_pc <= target_pc_arr[head_reg];
        head_reg      <= '0;
        tail_reg      <= '0;
        count_reg     <= '0;
      end else begin
        head_reg  <= head_reg + ROB_ID_W'(commit_fire);
        tail_reg  <= tail_reg + ROB_ID_W'(issue_fire);
        count_reg <= count_reg + (ROB_ID_W+1)'(issue_fire) - (ROB_ID_W+1)'(commit_fire);
      end
    end
  end

  assign Q1_ready = busy_vec[Q1_ROB_id] && ready_vec[Q1_ROB_id];
  assign Q2_ready = busy_vec[Q2_ROB_id] && ready_vec[Q2_ROB_id];
  assign Q1_value = value_arr[Q1_ROB_id];
  assign Q2_value = value_arr[Q2_ROB_id];

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer checked against a queue-based model of
// program-order allocation, writeback, retire and roll-back.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ID_issue_valid;
  logic        ID_rd_valid;
  logic [4:0]  ID_rd;
  logic        ID_is_branch;
  logic        ROB_full;
  logic [3:0]  ROB_tail_id;
  logic        CDB_valid;
  logic [3:0]  CDB_ROB_id;
  logic [31:0] CDB_value;
  logic        CDB_mispredict;
  logic [31:0] CDB_target_pc;
  logic [3:0]  Q1_ROB_id;
  logic [3:0]  Q2_ROB_id;
  logic        Q1_ready;
  logic        Q2_ready;
  logic [31:0] Q1_value;
  logic [31:0] Q2_value;
  logic        RF_commit_valid;
  logic [4:0]  RF_commit_rd;
  logic [31:0] RF_commit_value;
  logic        ROB_roll_back_flag;
  logic [31:0] ROB_target_pc;

  reorder_buffer #(.ROB_SIZE(16), .ROB_ID_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ID_issue_valid(ID_issue_valid), .ID_rd_valid(ID_rd_valid), .ID_rd(ID_rd),
    .ID_is_branch(ID_is_branch), .ROB_full(ROB_full), .ROB_tail_id(ROB_tail_id),
    .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value),
    .CDB_mispredict(CDB_mispredict), .CDB_target_pc(CDB_target_pc),
    .Q1_ROB_id(Q1_ROB_id), .Q2_ROB_id(Q2_ROB_id), .Q1_ready(Q1_ready), .Q2_ready(Q2_ready),
    .Q1_value(Q1_value), .Q2_value(Q2_value),
    .RF_commit_valid(RF_commit_valid), .RF_commit_rd(RF_commit_rd),
    .RF_commit_value(RF_commit_value), .ROB_roll_back_flag(ROB_roll_back_flag),
    .ROB_target_pc(ROB_target_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        id;
    bit        rdv;
    bit [4:0]  rd;
    bit        br;
    bit        done;
    bit [31:0] val;
    bit        mp;
    bit [31:0] tpc;
  } ent_t;

  ent_t      rob_q[$];
  int        m_tail;
  bit        m_flag;
  bit        e_cv;
  bit        e_flag;
  bit [4:0]  e_rd;
  bit [31:0] e_val;
  bit [31:0] e_tpc;
  int        checks;
  int        errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_id(input int id);
    foreach (rob_q[i]) if (rob_q[i].id == id) return i;
    return -1;
  endfunction

  task automatic model_clear();
    rob_q.delete();
    m_tail = 0; m_flag = 0;
    e_cv = 0; e_flag = 0; e_rd = 0; e_val = 0; e_tpc = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #2;
    model_clear();
    check("rst_full", 32'(ROB_full), 32'd0);
    check("rst_tail_id", 32'(ROB_tail_id), 32'd0);
    check("rst_commit_valid", 32'(RF_commit_valid), 32'd0);
    check("rst_commit_rd", 32'(RF_commit_rd), 32'd0);
    check("rst_commit_value", RF_commit_value, 32'd0);
    check("rst_roll_back", 32'(ROB_roll_back_flag), 32'd0);
    check("rst_target_pc", ROB_target_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic drive(input int p_issue, input int p_cdb);
    rdy            = ($urandom_range(0, 9) != 0);
    ID_issue_valid = ($urandom_range(0, 99) < p_issue);
    ID_rd          = 5'($urandom_range(0, 31));
    ID_rd_valid    = (ID_rd != 5'd0) && ($urandom_range(0, 3) != 0);
    ID_is_branch   = ($urandom_range(0, 3) == 0);
    CDB_valid      = ($urandom_range(0, 99) < p_cdb);
    if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
      CDB_ROB_id = 4'(rob_q[$urandom_range(0, rob_q.size() - 1)].id);
    else
      CDB_ROB_id = 4'($urandom_range(0, 15));
    CDB_value      = $urandom;
    CDB_mispredict = ($urandom_range(0, 11) == 0);
    CDB_target_pc  = $urandom;
    if (rob_q.size() > 0 && $urandom_range(0, 1) == 0)
      Q1_ROB_id = 4'(rob_q[$urandom_range(0, rob_q.size() - 1)].id);
    else
      Q1_ROB_id = 4'($urandom_range(0, 15));
    Q2_ROB_id = 4'($urandom_range(0, 15));
  endtask

  task automatic check_outputs();
    int  idx;
    bit  exp_r;
    check("full", 32'(ROB_full), 32'(rob_q.size() == 16));
    check("tail_id", 32'(ROB_tail_id), 32'(m_tail));
    check("commit_valid", 32'(RF_commit_valid), 32'(e_cv));
    if (e_cv) begin
      check("commit_rd", 32'(RF_commit_rd), 32'(e_rd));
      check("commit_value", RF_commit_value, e_val);
    end
    check("roll_back", 32'(ROB_roll_back_flag), 32'(e_flag));
    if (e_flag) check("target_pc", ROB_target_pc, e_tpc);
    idx   = find_id(int'(Q1_ROB_id));
    exp_r = (idx >= 0) && rob_q[idx].done;
    check("q1_ready", 32'(Q1_ready), 32'(exp_r));
    if (exp_r) check("q1_value", Q1_value, rob_q[idx].val);
    idx   = find_id(int'(Q2_ROB_id));
    exp_r = (idx >= 0) && rob_q[idx].done;
    check("q2_ready", 32'(Q2_ready), 32'(exp_r));
    if (exp_r) check("q2_value", Q2_value, rob_q[idx].val);
  endtask

  // Apply this cycle's inputs to the model: what the next clock edge should do.
  task automatic model_step();
    bit   do_commit;
    bit   do_flush;
    bit   do_issue;
    int   idx;
    ent_t e;
    do_commit = rdy && rob_q.size() > 0 && rob_q[0].done;
    do_flush  = do_commit && rob_q[0].br && rob_q[0].mp;
    do_issue  = rdy && ID_issue_valid && (rob_q.size() < 16 || do_commit) && !m_flag && !do_flush;
    e_cv   = do_commit && rob_q[0].rdv;
    e_flag = do_flush;
    if (do_commit) begin
      e_rd  = rob_q[0].rd;
      e_val = rob_q[0].val;
      $display("[%0t] commit id=%0d rd=x%0d wr=%0d value=%h rollback=%0d",
               $time, rob_q[0].id, rob_q[0].rd, rob_q[0].rdv, rob_q[0].val, do_flush);
    end
    if (do_flush) e_tpc = rob_q[0].tpc;
    if (rdy && CDB_valid && !m_flag) begin
      idx = find_id(int'(CDB_ROB_id));
      if (idx >= 0) begin
        rob_q[idx].done = 1;
        rob_q[idx].val  = CDB_value;
        rob_q[idx].mp   = CDB_mispredict;
        rob_q[idx].tpc  = CDB_target_pc;
      end
    end
    if (do_flush) begin
      rob_q.delete();
      m_tail = 0;
    end else begin
      if (do_commit) void'(rob_q.pop_front());
      if (do_issue) begin
        e.id = m_tail; e.rdv = ID_rd_valid; e.rd = ID_rd; e.br = ID_is_branch;
        e.done = 0; e.val = 0; e.mp = 0; e.tpc = 0;
        rob_q.push_back(e);
        m_tail = (m_tail + 1) % 16;
      end
    end
    m_flag = e_flag;
  endtask

  int p_issue_tab[4] = '{80, 50, 30, 90};
  int p_cdb_tab[4]   = '{15, 50, 85, 60};

  initial begin
    clk = 0; rst = 0; rdy = 0;
    ID_issue_valid = 0; ID_rd_valid = 0; ID_rd = 0; ID_is_branch = 0;
    CDB_valid = 0; CDB_ROB_id = 0; CDB_value = 0; CDB_mispredict = 0; CDB_target_pc = 0;
    Q1_ROB_id = 0; Q2_ROB_id = 0;
    checks = 0; errors = 0;
    #1;
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      if (ph == 4) do_reset();
      for (int c = 0; c < 250; c++) begin
        drive(p_issue_tab[ph % 4], p_cdb_tab[ph % 4]);
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk); #1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
